// File: rtl/pbkdf2_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pbkdf2_iter_ctrl
//  Purpose  : Sequences one PBKDF2-HMAC-SHA256 output block T_i over a single
//             external hmac_sha256 core:
//               U1 = HMAC(P, S || INT(i)), Uj = HMAC(P, Uj-1),
//               T  = U1 ^ U2 ^ ... ^ Uc
//             Owns the iteration counter, the U chaining register and the
//             XOR accumulator.
//  Ports    : clk_i/rst_i        clock, synchronous active-high reset
//             pwd_i/salt_i       512-bit left-aligned password and salt
//             salt_len_i         salt length in bytes (0..51 legal)
//             iter_i/blk_idx_i   iteration count c (0 -> 1), block index i
//             v_i/r_o            request handshake
//             dk_o/err_o         derived block T_i, salt-length error flag
//             v_o/r_i            result handshake, result held until r_i
//             hmac_key_o/msg_o/len_o/v_o, hmac_r_i   request to the core
//             hmac_prf_i/v_i, hmac_r_o               response from the core
//  Revision : 1.0  initial release
// ============================================================================
module pbkdf2_iter_ctrl #(
    parameter int ITER_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [511:0]      pwd_i,
    input  logic [511:0]      salt_i,
    input  logic [5:0]        salt_len_i,
    input  logic [ITER_W-1:0] iter_i,
    input  logic [ITER_W-1:0] blk_idx_i,
    input  logic              v_i,
    output logic              r_o,
    output logic [255:0]      dk_o,
    output logic              err_o,
    output logic              v_o,
    input  logic              r_i,
    output logic [511:0]      hmac_key_o,
    output logic [511:0]      hmac_msg_o,
    output logic [5:0]        hmac_len_o,
    output logic              hmac_v_o,
    input  logic              hmac_r_i,
    input  logic [255:0]      hmac_prf_i,
    input  logic              hmac_v_i,
    output logic              hmac_r_o
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [5:0]        c_MAX_SALT_LEN = 6'd51;
    localparam logic [5:0]        c_IDX_BYTES    = 6'd4;
    localparam logic [5:0]        c_U_LEN        = 6'd32;
    localparam logic [ITER_W-1:0] c_ONE          = ITER_W'(1);

    logic [1:0]        r_state;
    logic [511:0]      r_key;
    logic [511:0]      r_msg;     // upper half doubles as the U chaining register
    logic [5:0]        r_len;
    logic [ITER_W-1:0] r_cnt;
    logic [255:0]      r_t;
    logic [255:0]      r_dk;
    logic              r_err;
    logic              r_v;
    logic              r_hmac_v;
    logic              r_hmac_r;

    logic [ITER_W-1:0] w_iter_eff;
    logic              w_salt_bad;
    logic [9:0]        w_idx_shift;
    logic [511:0]      w_first_msg;
    logic [5:0]        w_first_len;
    logic [255:0]      w_t_next;
    logic              w_last;

    // An iteration count of zero still produces U1.
    assign w_iter_eff  = (iter_i == '0) ? c_ONE : iter_i;
    assign w_salt_bad  = (salt_len_i > c_MAX_SALT_LEN);

    // The block index lands big-endian directly after the last salt byte.
    assign w_idx_shift = 10'd480 - {1'b0, salt_len_i, 3'b000};
    assign w_first_msg = salt_i | ({{(512-ITER_W){1'b0}}, blk_idx_i} << w_idx_shift);
    assign w_first_len = salt_len_i + c_IDX_BYTES;

    assign w_t_next    = r_t ^ hmac_prf_i;
    assign w_last      = (r_cnt == c_ONE);

    // Ready is a pure decode of IDLE, forced low while reset is held.
    assign r_o        = (r_state == c_ST_IDLE) && !rst_i;
    assign dk_o       = r_dk;
    assign err_o      = r_err;
    assign v_o        = r_v;
    assign hmac_key_o = r_key;
    assign hmac_msg_o = r_msg;
    assign hmac_len_o = r_len;
    assign hmac_v_o   = r_hmac_v;
    assign hmac_r_o   = r_hmac_r;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_ST_IDLE;
            r_key    <= '0;
            r_msg    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_t      <= '0;
            r_dk     <= '0;
            r_err    <= 1'b0;
            r_v      <= 1'b0;
            r_hmac_v <= 1'b0;
            r_hmac_r <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (v_i) begin
                        r_key <= pwd_i;
                        r_msg <= w_first_msg;
                        r_len <= w_first_len;
                        r_cnt <= w_iter_eff;
                        r_t   <= '0;
                        r_dk  <= '0;
                        if (w_salt_bad) begin
                            // Reject without touching the core.
                            r_err   <= 1'b1;
                            r_v     <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_err    <= 1'b0;
                            r_hmac_v <= 1'b1;
                            r_state  <= c_ST_ISSUE;
                        end
                    end
                end

                c_ST_ISSUE: begin
                    // key/msg/len are registers and stay frozen until transfer.
                    if (hmac_r_i) begin
                        r_hmac_v <= 1'b0;
                        r_hmac_r <= 1'b1;
                        r_state  <= c_ST_WAIT;
                    end
                end

                c_ST_WAIT: begin
                    if (hmac_v_i) begin
                        r_hmac_r <= 1'b0;
                        r_msg    <= {hmac_prf_i, 256'b0};
                        r_len    <= c_U_LEN;
                        r_t      <= w_t_next;
                        r_cnt    <= r_cnt - c_ONE;
                        if (w_last) begin
                            r_dk    <= w_t_next;
                            r_v     <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_hmac_v <= 1'b1;
                            r_state  <= c_ST_ISSUE;
                        end
                    end
                end

                c_ST_DONE: begin
                    if (r_i) begin
                        r_v     <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
